vga_timing: RTL and testbench

Pixel-timing generator for the 640x480 @ 60 Hz display path. It runs on the 25 MHz pixel clock and produces the raster coordinates (DrawX, DrawY) and the active-video flag (blank) that every sprite and background drawer consumes. It also produces the active-low sync pulses for the VGA connector, delayed to line up with the drawers' one-cycle registered colour output. A frame_start pulse and a frame counter drive game-logic and sprite-animation updates.

---
 rtl/vga_timing.sv | 101 ++++++++++
 tb/tb_vga_timing.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 raster counter, blank/sync decode and frame counter
// Decodes use the next counter value so every registered output lines up with DrawX/DrawY.
module vga_timing #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 1
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] next_x;
   logic [9:0] next_y;
   logic       hs_raw;
   logic       vs_raw;

   always_comb begin
      next_x = DrawX + 10'd1;
      next_y = DrawY;
      if (DrawX == H_LAST) begin
         next_x = '0;
         next_y = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
      end
   end

   // Reset parks the counters on the last position so release lands on (0, 0).
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         DrawX       <= H_LAST;
         DrawY       <= V_LAST;
         blank       <= 1'b0;
         hs_raw      <= 1'b1;
         vs_raw      <= 1'b1;
         frame_start <= 1'b0;
         frame_count <= 8'hFF;
      end else begin
         DrawX       <= next_x;
         DrawY       <= next_y;
         blank       <= (next_x < H_VIS) && (next_y < V_VIS);
         hs_raw      <= !((next_x >= HS_START) && (next_x < HS_END));
         vs_raw      <= !((next_y >= VS_START) && (next_y < VS_END));
         frame_start <= (next_x == 10'd0) && (next_y == 10'd0);
         if ((next_x == 10'd0) && (next_y == 10'd0))
            frame_count <= frame_count + 8'd1;
      end
   end

   // Sync pins trail the decode to match the drawers' registered colour path.
   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign hs = hs_raw;
         assign vs = vs_raw;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] hs_pipe;
         logic [SYNC_DELAY-1:0] vs_pipe;

         always_ff @(posedge vga_clk) begin
            if (!reset_n) begin
               hs_pipe <= '1;
               vs_pipe <= '1;
            end else begin
               hs_pipe[0] <= hs_raw;
               vs_pipe[0] <= vs_raw;
               for (int i = 1; i < SYNC_DELAY; i++) begin
                  hs_pipe[i] <= hs_pipe[i-1];
                  vs_pipe[i] <= vs_pipe[i-1];
               end
            end
         end

         assign hs = hs_pipe[SYNC_DELAY-1];
         assign vs = vs_pipe[SYNC_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed bench for vga_timing
// Full-frame and wrap behaviour run on scaled instances to keep the run short.
`timescale 1ns/1ps
module tb_vga_timing;

   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b0;
   int         vectors = 0;
   int         errors  = 0;

   always #20 vga_clk = ~vga_clk;

   logic [9:0] d_x, d_y;
   logic       d_blank, d_hs, d_vs, d_fs;
   logic [7:0] d_fc;
   logic [9:0] z_x, z_y;
   logic       z_blank, z_hs, z_vs, z_fs;
   logic [7:0] z_fc;
   logic [9:0] m_x, m_y;
   logic       m_blank, m_hs, m_vs, m_fs;
   logic [7:0] m_fc;
   logic [9:0] s_x, s_y;
   logic       s_blank, s_hs, s_vs, s_fs;
   logic [7:0] s_fc;

   vga_timing dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
      .hs(d_hs), .vs(d_vs), .frame_start(d_fs), .frame_count(d_fc));

   vga_timing #(.SYNC_DELAY(0)) dut_d0 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(z_x), .DrawY(z_y), .blank(z_blank),
      .hs(z_hs), .vs(z_vs), .frame_start(z_fs), .frame_count(z_fc));

   // 24 x 14 raster: 336 cycles per frame, vs low on lines 10..11
   vga_timing #(.H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(1)) dut_mid (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(m_x), .DrawY(m_y), .blank(m_blank),
      .hs(m_hs), .vs(m_vs), .frame_start(m_fs), .frame_count(m_fc));

   // 8 x 5 raster: 40 cycles per frame
   vga_timing #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
                .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_DELAY(1)) dut_small (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
      .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .frame_count(s_fc));

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (5) tick();
      vectors++; if (d_x !== 10'd799) begin errors++; $display("FAIL reset_x got %0d want 799", d_x); end
      vectors++; if (d_y !== 10'd524) begin errors++; $display("FAIL reset_y got %0d want 524", d_y); end
      vectors++; if ({d_blank, d_hs, d_vs, d_fs} !== 4'b0110) begin errors++; $display("FAIL reset_flags got %b want 0110", {d_blank, d_hs, d_vs, d_fs}); end
      vectors++; if (d_fc !== 8'hFF) begin errors++; $display("FAIL reset_fc got %h want ff", d_fc); end
      vectors++; if ({s_x, s_y} !== {10'd7, 10'd4}) begin errors++; $display("FAIL reset_small_xy got %0d,%0d want 7,4", s_x, s_y); end
      reset_n = 1'b1;
      tick();
      vectors++; if ({d_x, d_y} !== 20'd0) begin errors++; $display("FAIL release_xy got %0d,%0d want 0,0", d_x, d_y); end
      vectors++; if ({d_blank, d_fs, d_hs, d_vs} !== 4'b1111) begin errors++; $display("FAIL release_flags got %b want 1111", {d_blank, d_fs, d_hs, d_vs}); end
      vectors++; if (d_fc !== 8'h00) begin errors++; $display("FAIL release_fc got %h want 00", d_fc); end
   endtask

   task automatic test_line_scan();
      int x_err = 0, hi_cnt = 0, hi_min = 1023, hi_max = -1;
      int hs_cnt = 0, hs_first = -1, z_cnt = 0, z_first = -1, vs_low = 0;
      for (int i = 0; i < 800; i++) begin
         if (d_x !== 10'(i) || d_y !== 10'd0) x_err++;
         if (d_blank) begin hi_cnt++; if (i < hi_min) hi_min = i; hi_max = i; end
         if (!d_hs) begin hs_cnt++; if (hs_first < 0) hs_first = i; end
         if (!z_hs) begin z_cnt++; if (z_first < 0) z_first = i; end
         if (!d_vs || !z_vs) vs_low++;
         tick();
      end
      vectors++; if (x_err !== 0) begin errors++; $display("FAIL line_x_seq got %0d bad cycles want 0", x_err); end
      vectors++; if ({d_x, d_y} !== {10'd0, 10'd1}) begin errors++; $display("FAIL line_wrap got %0d,%0d want 0,1", d_x, d_y); end
      vectors++; if (hi_cnt !== 640) begin errors++; $display("FAIL blank_count got %0d want 640", hi_cnt); end
      vectors++; if (hi_min !== 0 || hi_max !== 639) begin errors++; $display("FAIL blank_range got %0d..%0d want 0..639", hi_min, hi_max); end
      vectors++; if (hs_cnt !== 96) begin errors++; $display("FAIL hs_width got %0d want 96", hs_cnt); end
      vectors++; if (hs_first !== 657) begin errors++; $display("FAIL hs_start got %0d want 657", hs_first); end
      vectors++; if (z_cnt !== 96) begin errors++; $display("FAIL hs_d0_width got %0d want 96", z_cnt); end
      vectors++; if (z_first !== 656) begin errors++; $display("FAIL hs_d0_start got %0d want 656", z_first); end
      vectors++; if (vs_low !== 0) begin errors++; $display("FAIL vs_line0 got %0d low cycles want 0", vs_low); end
   endtask

   task automatic test_full_frame();
      int n = 0, cycles = 0, vs_low = 0, vs_first = -1, vs_last = -1;
      int vs_fx = -1, vs_fy = -1, blank_hi = 0, blank_late = 0;
      logic [7:0] fc0;
      while (!m_fs && n < 400) begin tick(); n++; end
      vectors++; if (!m_fs) begin errors++; $display("FAIL frame_wait got timeout want frame_start"); end
      fc0 = m_fc;
      do begin
         if (!m_vs) begin
            vs_low++; vs_last = cycles;
            if (vs_first < 0) begin vs_first = cycles; vs_fx = int'(m_x); vs_fy = int'(m_y); end
         end
         if (m_blank) begin blank_hi++; if (m_y >= 10'd8) blank_late++; end
         tick();
         cycles++;
      end while (!m_fs && cycles < 1000);
      vectors++; if (cycles !== 336) begin errors++; $display("FAIL frame_period got %0d want 336", cycles); end
      vectors++; if (m_fc !== 8'(fc0 + 8'd1)) begin errors++; $display("FAIL frame_count_inc got %h want %h", m_fc, 8'(fc0 + 8'd1)); end
      vectors++; if (vs_low !== 48 || vs_last - vs_first !== 47) begin errors++; $display("FAIL vs_width got %0d span %0d want 48", vs_low, vs_last - vs_first + 1); end
      vectors++; if (vs_fx !== 1 || vs_fy !== 10) begin errors++; $display("FAIL vs_start got %0d,%0d want 1,10", vs_fx, vs_fy); end
      vectors++; if (blank_hi !== 128) begin errors++; $display("FAIL frame_blank got %0d want 128", blank_hi); end
      vectors++; if (blank_late !== 0) begin errors++; $display("FAIL blank_vporch got %0d want 0", blank_late); end
   endtask

   task automatic test_wrap();
      int fs_cnt = 0, off_phase = 0;
      logic saw_wrap = 1'b0;
      logic [7:0] prev_fc = 8'h00, first_fc = 8'h55, last_fc = 8'h55;
      reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
      for (int i = 0; i < 257 * 40; i++) begin
         if (s_fs) begin
            fs_cnt++;
            if (i % 40 != 0) off_phase++;
            if (fs_cnt == 1) first_fc = s_fc;
            if (fs_cnt > 1 && prev_fc == 8'hFF && s_fc == 8'h00) saw_wrap = 1'b1;
            last_fc = s_fc;
         end
         prev_fc = s_fc;
         tick();
      end
      vectors++; if (fs_cnt !== 257) begin errors++; $display("FAIL wrap_fs_count got %0d want 257", fs_cnt); end
      vectors++; if (off_phase !== 0) begin errors++; $display("FAIL wrap_fs_phase got %0d want 0", off_phase); end
      vectors++; if (first_fc !== 8'h00) begin errors++; $display("FAIL wrap_first_fc got %h want 00", first_fc); end
      vectors++; if (saw_wrap !== 1'b1 || last_fc !== 8'h00) begin errors++; $display("FAIL wrap_fc got wrap=%b last=%h want 1/00", saw_wrap, last_fc); end
   endtask

   task automatic test_mid_frame_reset();
      int n = 0, spurious = 0;
      reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
      while (!(d_x == 10'd700 && d_y == 10'd1) && n < 2000) begin tick(); n++; end
      vectors++; if (d_x !== 10'd700 || d_hs !== 1'b0) begin errors++; $display("FAIL midreset_pre got x=%0d hs=%b want 700/0", d_x, d_hs); end
      reset_n = 1'b0;
      tick();
      vectors++; if ({d_x, d_y} !== {10'd799, 10'd524}) begin errors++; $display("FAIL midreset_xy got %0d,%0d want 799,524", d_x, d_y); end
      vectors++; if ({d_blank, d_hs, d_vs, d_fs} !== 4'b0110 || d_fc !== 8'hFF) begin errors++; $display("FAIL midreset_out got %b fc=%h want 0110 ff", {d_blank, d_hs, d_vs, d_fs}, d_fc); end
      vectors++; if ({m_x, m_y} !== {10'd23, 10'd13}) begin errors++; $display("FAIL midreset_mid got %0d,%0d want 23,13", m_x, m_y); end
      reset_n = 1'b1;
      tick();
      vectors++; if ({d_x, d_y} !== 20'd0 || d_fs !== 1'b1 || d_fc !== 8'h00) begin errors++; $display("FAIL midreset_restart got %0d,%0d fs=%b fc=%h want 0,0 1 00", d_x, d_y, d_fs, d_fc); end
      for (int i = 0; i < 657; i++) begin
         if (!d_hs || !d_vs) spurious++;
         tick();
      end
      vectors++; if (spurious !== 0) begin errors++; $display("FAIL midreset_sync got %0d low cycles want 0", spurious); end
      vectors++; if (d_x !== 10'd657 || d_hs !== 1'b0) begin errors++; $display("FAIL midreset_hs got x=%0d hs=%b want 657/0", d_x, d_hs); end
   endtask

   initial begin
      test_reset();
      test_line_scan();
      test_full_frame();
      test_wrap();
      test_mid_frame_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
